add_sub_seq: RTL and testbench
==============================

# add_sub_seq

Parametrised multi-cycle adder/subtractor, successor to the 4-bit ripple-carry binary adder. It processes a WIDTH-bit operation in CHUNK-bit slices, one slice per clock, through a single CHUNK-bit ripple slice. It adds subtract mode, a start/busy/done handshake, and signed-overflow and zero flags. It sits in the datapath wherever a wide add is needed but a full-width ripple chain is too slow or too large.

## Interface
- WIDTH, 16, operand/result width in bits; must be a positive multiple of CHUNK.
- CHUNK, 4, bits processed per clock; 1 ≤ CHUNK ≤ WIDTH.
- Derived: N = WIDTH/CHUNK, the number of slice cycles.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on rising edge.
- sub  input  1  0 = add, 1 = subtract; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- c_in  input  1  carry-in (add) / borrow-in (sub); sampled with start.
- busy  output  1  high while slices are being computed.
- done  output  1  one-cycle pulse; result outputs are valid from this cycle.
- s  output  WIDTH  result.
- c_out  output  1  carry out of MSB (for sub: 1 = no borrow).
- ovf  output  1  two's-complement signed overflow.
- zero  output  1  s == 0.

## Operation
- Sub encoding:
  - B operand = b XOR {WIDTH{sub}}.
  - Initial carry = c_in XOR sub.
  - sub=1, c_in=0 gives a−b; sub=1, c_in=1 gives a−b−1.
- FSM has three states: IDLE, RUN, DONE.
  - IDLE: start=1 → latch a, B operand, and initial carry; slice counter cnt=0; go to RUN.
  - RUN: each edge adds slice cnt (bits cnt·CHUNK+CHUNK−1 … cnt·CHUNK) with the running carry, stores sum bits and the new carry, and increments cnt.
  - RUN exit: on the edge that processes slice N−1, go to DONE. On that same edge, load s, c_out, ovf and zero, and assert done.
  - DONE: start=1 → accept a new operation exactly as in IDLE (go to RUN). Otherwise → IDLE.
- start is ignored while in RUN. Operand inputs are don't-care except on the accepting edge.
- Flags:
  - ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
  - zero = (s == 0), computed on the final sum.
- Result registers s, c_out, ovf and zero hold their value until the next operation completes or rst is asserted. They never show partial sums.
- Arithmetic is modulo 2^WIDTH; the carry beyond the MSB goes only to c_out.

## Timing
- Reset: when rst=1 at an edge, the next state is IDLE and cnt=0. Outputs after reset: busy=0, done=0, s=0, c_out=0, ovf=0, zero=0.
  - rst has priority over start at the same edge.
  - rst during RUN aborts the operation; done does not pulse for it.
- busy = (state == RUN). It rises on the edge after start is sampled and falls on the edge that asserts done.
- done rises exactly N edges after the accepting edge and is high for exactly one cycle, in state DONE.
- Latency is N cycles (4 for the defaults). Back-to-back throughput is one operation per N+1 cycles, with start held high or reasserted while done is high.
- N=1 (CHUNK=WIDTH): one RUN cycle, then DONE. Latency is 1.

## Test plan
- Defaults, add 8+8: a=0x0008, b=0x0008, c_in=0, sub=0, start pulsed for 1 cycle → busy high for 4 cycles, then done pulse; s=0x0010, c_out=0, ovf=0, zero=0.
- Carry out and wrap: a=0xFFFF, b=0x0001, add → s=0x0000, c_out=1, zero=1, ovf=0. Signed overflow: a=0x7FFF, b=0x0001, add → s=0x8000, c_out=0, ovf=1.
- Subtract:
  - a=0x0005, b=0x0007, sub=1, c_in=0 → s=0xFFFE, c_out=0, ovf=0.
  - a=0x8000, b=0x0001, sub=1 → s=0x7FFF, c_out=1, ovf=1.
  - a=0x0005, b=0x0005, sub=1, c_in=1 → s=0xFFFF, c_out=0.
- Handshake:
  - start pulsed again during RUN with different operands → ignored; result matches the first operation.
  - start held high continuously → done pulses every 5 cycles, and each result matches the operands present on its accepting edge.
- Reset mid-operation: rst=1 in the 2nd RUN cycle → next cycle busy=0, done=0, s=0; no done pulse follows. A new start afterwards completes normally with 4-cycle latency.
- Parameter corner, WIDTH=4, CHUNK=4: a=8, b=8, c_in=1, add → after 1 RUN cycle done=1, s=0x1, c_out=1, ovf=1. Repeat with WIDTH=8, CHUNK=1 for random operands against a reference sum.

Source files
------------

// File: rtl/add_sub_seq_if.sv
// Request/result bundle for the multi-cycle adder/subtractor.
// The requester owns the operands and start; the datapath owns the status and results.
interface add_sub_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             ovf;
    logic             zero;

    modport master (
        output start, sub, a, b, c_in,
        input  busy, done, s, c_out, ovf, zero
    );

    modport slave (
        input  start, sub, a, b, c_in,
        output busy, done, s, c_out, ovf, zero
    );
endinterface

// File: rtl/add_sub_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit ripple slice per clock, LSB slice first.
// WIDTH must be a positive multiple of CHUNK.
module add_sub_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic          clk,
    input logic          rst,
    add_sub_seq_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [IW-1:0]    base;
    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK:0]   sl_sum;
    logic [WIDTH-1:0] sum_full;
    logic             last;
    logic             ovf_n;

    // sum_full merges the current slice into the partial sum so the final
    // edge can load the complete result without an extra cycle.
    always_comb begin
        base     = IW'(int'(cnt) * CHUNK);
        a_sl     = a_q[base +: CHUNK];
        b_sl     = b_q[base +: CHUNK];
        sl_sum   = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry};
        sum_full = acc;
        sum_full[base +: CHUNK] = sl_sum[CHUNK-1:0];
        last     = (cnt == CW'(N - 1));
        // carry into the MSB is recovered from the MSB's own inputs and sum bit
        ovf_n    = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sum_full[WIDTH-1] ^ sl_sum[CHUNK];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.s     <= '0;
            bus.c_out <= 1'b0;
            bus.ovf   <= 1'b0;
            bus.zero  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b ^ {WIDTH{bus.sub}};
                        carry    <= bus.c_in ^ bus.sub;
                        cnt      <= '0;
                        state    <= RUN;
                        bus.busy <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc   <= sum_full;
                    carry <= sl_sum[CHUNK];
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        state     <= DONE;
                        bus.busy  <= 1'b0;
                        bus.done  <= 1'b1;
                        bus.s     <= sum_full;
                        bus.c_out <= sl_sum[CHUNK];
                        bus.ovf   <= ovf_n;
                        bus.zero  <= (sum_full == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_add_sub_seq.sv
// Directed bench for add_sub_seq: default 16/4 build, N=1 corner (4/4) and bit-serial (8/1).
module tb_add_sub_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    add_sub_seq_if #(.WIDTH(16)) if0 ();
    add_sub_seq_if #(.WIDTH(4))  if1 ();
    add_sub_seq_if #(.WIDTH(8))  if2 ();

    add_sub_seq #(.WIDTH(16), .CHUNK(4)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    add_sub_seq #(.WIDTH(4),  .CHUNK(4)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    add_sub_seq #(.WIDTH(8),  .CHUNK(1)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    // Launch one op on the 16-bit unit; returns edges to done and busy-high samples.
    task automatic do_op16(input logic [15:0] a, input logic [15:0] b, input logic sb,
                           input logic ci, output int lat, output int bc);
        if0.a = a; if0.b = b; if0.sub = sb; if0.c_in = ci; if0.start = 1'b1;
        @(posedge clk); #1;
        if0.start = 1'b0;
        lat = 0; bc = 0;
        while (!if0.done && lat < 20) begin
            if (if0.busy) bc++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({if0.busy, if0.done, if0.c_out, if0.ovf, if0.zero} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {if0.busy, if0.done, if0.c_out, if0.ovf, if0.zero});
        end
        checks++;
        if (if0.s !== 16'h0000) begin
            failures++; $display("FAIL reset_s got=%h exp=0000", if0.s);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        int lat, bc;
        do_op16(16'h0008, 16'h0008, 1'b0, 1'b0, lat, bc);
        checks++;
        if (lat !== 4 || bc !== 4) begin
            failures++; $display("FAIL add_timing lat=%0d busy=%0d exp lat=4 busy=4", lat, bc);
        end
        checks++;
        if ({if0.s, if0.c_out, if0.ovf, if0.zero} !== {16'h0010, 3'b000}) begin
            failures++;
            $display("FAIL add_8_8 got s=%h c=%b o=%b z=%b exp s=0010 c=0 o=0 z=0",
                     if0.s, if0.c_out, if0.ovf, if0.zero);
        end
        @(posedge clk); #1;
        checks++;
        if (if0.done !== 1'b0 || if0.s !== 16'h0010) begin
            failures++; $display("FAIL add_hold done=%b s=%h exp done=0 s=0010", if0.done, if0.s);
        end
    endtask

    task automatic test_carry_wrap();
        int lat, bc;
        do_op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, bc);
        checks++;
        if ({if0.s, if0.c_out, if0.ovf, if0.zero} !== {16'h0000, 3'b101}) begin
            failures++;
            $display("FAIL wrap got s=%h c=%b o=%b z=%b exp s=0000 c=1 o=0 z=1",
                     if0.s, if0.c_out, if0.ovf, if0.zero);
        end
        do_op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, bc);
        checks++;
        if ({if0.s, if0.c_out, if0.ovf, if0.zero} !== {16'h8000, 3'b010}) begin
            failures++;
            $display("FAIL sovf got s=%h c=%b o=%b z=%b exp s=8000 c=0 o=1 z=0",
                     if0.s, if0.c_out, if0.ovf, if0.zero);
        end
    endtask

    task automatic test_sub();
        int lat, bc;
        do_op16(16'h0005, 16'h0007, 1'b1, 1'b0, lat, bc);
        checks++;
        if ({if0.s, if0.c_out, if0.ovf, if0.zero} !== {16'hFFFE, 3'b000}) begin
            failures++;
            $display("FAIL sub_5_7 got s=%h c=%b o=%b z=%b exp s=fffe c=0 o=0 z=0",
                     if0.s, if0.c_out, if0.ovf, if0.zero);
        end
        do_op16(16'h8000, 16'h0001, 1'b1, 1'b0, lat, bc);
        checks++;
        if ({if0.s, if0.c_out, if0.ovf, if0.zero} !== {16'h7FFF, 3'b110}) begin
            failures++;
            $display("FAIL sub_8000_1 got s=%h c=%b o=%b z=%b exp s=7fff c=1 o=1 z=0",
                     if0.s, if0.c_out, if0.ovf, if0.zero);
        end
        do_op16(16'h0005, 16'h0005, 1'b1, 1'b1, lat, bc);
        checks++;
        if ({if0.s, if0.c_out, if0.zero} !== {16'hFFFF, 2'b00}) begin
            failures++;
            $display("FAIL sub_borrow got s=%h c=%b z=%b exp s=ffff c=0 z=0",
                     if0.s, if0.c_out, if0.zero);
        end
    endtask

    task automatic test_ignore_start();
        if0.a = 16'h0001; if0.b = 16'h0002; if0.sub = 1'b0; if0.c_in = 1'b0; if0.start = 1'b1;
        @(posedge clk); #1;
        if0.start = 1'b0;
        @(posedge clk); #1;
        if0.a = 16'h0100; if0.b = 16'h0200; if0.sub = 1'b1; if0.start = 1'b1;
        @(posedge clk); #1;
        if0.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (if0.done !== 1'b1 || if0.s !== 16'h0003) begin
            failures++; $display("FAIL ignore_start done=%b s=%h exp done=1 s=0003", if0.done, if0.s);
        end
        @(posedge clk); #1;
        checks++;
        if (if0.done !== 1'b0 || if0.busy !== 1'b0) begin
            failures++; $display("FAIL ignore_idle done=%b busy=%b exp 0 0", if0.done, if0.busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ta [3];
        logic [15:0] tb_ [3];
        logic        tsub [3];
        logic        tci [3];
        logic [17:0] texp [3];
        logic        nd_ok;
        ta[0] = 16'h1234; tb_[0] = 16'h1111; tsub[0] = 1'b0; tci[0] = 1'b0; texp[0] = {16'h2345, 2'b00};
        ta[1] = 16'h1000; tb_[1] = 16'h0001; tsub[1] = 1'b1; tci[1] = 1'b0; texp[1] = {16'h0FFF, 2'b10};
        ta[2] = 16'hFFFF; tb_[2] = 16'h0000; tsub[2] = 1'b0; tci[2] = 1'b1; texp[2] = {16'h0000, 2'b11};
        if0.a = ta[0]; if0.b = tb_[0]; if0.sub = tsub[0]; if0.c_in = tci[0]; if0.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i < 2) begin
                if0.a = ta[i+1]; if0.b = tb_[i+1]; if0.sub = tsub[i+1]; if0.c_in = tci[i+1];
            end else begin
                if0.start = 1'b0;
            end
            nd_ok = 1'b1;
            repeat (3) begin
                @(posedge clk); #1;
                if (if0.done) nd_ok = 1'b0;
            end
            @(posedge clk); #1;
            checks++;
            if (if0.done !== 1'b1 || nd_ok !== 1'b1 || {if0.s, if0.c_out, if0.zero} !== texp[i]) begin
                failures++;
                $display("FAIL b2b_%0d done=%b early_ok=%b s=%h c=%b z=%b exp done=1 s=%h c=%b z=%b",
                         i, if0.done, nd_ok, if0.s, if0.c_out, if0.zero,
                         texp[i][17:2], texp[i][1], texp[i][0]);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (if0.done !== 1'b0 || if0.busy !== 1'b0) begin
            failures++; $display("FAIL b2b_end done=%b busy=%b exp 0 0", if0.done, if0.busy);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        logic seen;
        if0.a = 16'h0008; if0.b = 16'h0008; if0.sub = 1'b0; if0.c_in = 1'b0; if0.start = 1'b1;
        @(posedge clk); #1;
        if0.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({if0.busy, if0.done, if0.s} !== 18'h0) begin
            failures++;
            $display("FAIL rst_mid busy=%b done=%b s=%h exp 0 0 0000", if0.busy, if0.done, if0.s);
        end
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (if0.done) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++; $display("FAIL rst_no_done got done pulse exp none");
        end
        do_op16(16'h0100, 16'h0023, 1'b0, 1'b0, lat, bc);
        checks++;
        if (lat !== 4 || if0.s !== 16'h0123) begin
            failures++; $display("FAIL rst_restart lat=%0d s=%h exp lat=4 s=0123", lat, if0.s);
        end
    endtask

    task automatic test_n1();
        if1.a = 4'h8; if1.b = 4'h8; if1.sub = 1'b0; if1.c_in = 1'b1; if1.start = 1'b1;
        @(posedge clk); #1;
        if1.start = 1'b0;
        checks++;
        if (if1.busy !== 1'b1 || if1.done !== 1'b0) begin
            failures++; $display("FAIL n1_busy busy=%b done=%b exp 1 0", if1.busy, if1.done);
        end
        @(posedge clk); #1;
        checks++;
        if ({if1.done, if1.s, if1.c_out, if1.ovf, if1.zero} !== {1'b1, 4'h1, 3'b110}) begin
            failures++;
            $display("FAIL n1_add done=%b s=%h c=%b o=%b z=%b exp done=1 s=1 c=1 o=1 z=0",
                     if1.done, if1.s, if1.c_out, if1.ovf, if1.zero);
        end
        if1.a = 4'h3; if1.b = 4'h4; if1.sub = 1'b1; if1.c_in = 1'b0; if1.start = 1'b1;
        @(posedge clk); #1;
        if1.start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({if1.done, if1.s, if1.c_out, if1.ovf} !== {1'b1, 4'hF, 2'b00}) begin
            failures++;
            $display("FAIL n1_sub done=%b s=%h c=%b o=%b exp done=1 s=f c=0 o=0",
                     if1.done, if1.s, if1.c_out, if1.ovf);
        end
    endtask

    task automatic test_chunk1();
        logic [7:0] ra, rb, bb;
        logic       sb, ci, e_ovf, e_z;
        logic [8:0] full;
        int         lat;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                ra = 8'h80; rb = 8'h01; sb = 1'b1; ci = 1'b0;
            end else begin
                ra = 8'($urandom_range(0, 255));
                rb = 8'($urandom_range(0, 255));
                sb = 1'($urandom_range(0, 1));
                ci = 1'($urandom_range(0, 1));
            end
            bb    = rb ^ {8{sb}};
            full  = {1'b0, ra} + {1'b0, bb} + {8'b0, ci ^ sb};
            e_ovf = (ra[7] == bb[7]) && (full[7] != ra[7]);
            e_z   = (full[7:0] == 8'h00);
            if2.a = ra; if2.b = rb; if2.sub = sb; if2.c_in = ci; if2.start = 1'b1;
            @(posedge clk); #1;
            if2.start = 1'b0;
            lat = 0;
            while (!if2.done && lat < 30) begin
                @(posedge clk); #1;
                lat++;
            end
            checks++;
            if (lat !== 8 || {if2.s, if2.c_out, if2.ovf, if2.zero} !== {full[7:0], full[8], e_ovf, e_z}) begin
                failures++;
                $display("FAIL chunk1_%0d a=%h b=%h sub=%b cin=%b lat=%0d s=%h c=%b o=%b z=%b exp lat=8 s=%h c=%b o=%b z=%b",
                         i, ra, rb, sb, ci, lat, if2.s, if2.c_out, if2.ovf, if2.zero,
                         full[7:0], full[8], e_ovf, e_z);
            end
        end
    endtask

    initial begin
        if0.start = 1'b0; if0.sub = 1'b0; if0.a = '0; if0.b = '0; if0.c_in = 1'b0;
        if1.start = 1'b0; if1.sub = 1'b0; if1.a = '0; if1.b = '0; if1.c_in = 1'b0;
        if2.start = 1'b0; if2.sub = 1'b0; if2.a = '0; if2.b = '0; if2.c_in = 1'b0;
        test_reset();
        test_add();
        test_carry_wrap();
        test_sub();
        test_reset_mid();
        test_ignore_start();
        test_back_to_back();
        test_n1();
        test_chunk1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
